// File: rtl/alu_n_pkg.sv
// Shared types for the serial ALU: op codes, FSM states and the carry-seed rule.
package alu_n_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Carry loaded at accept: c_in for ADD, 1 for SUB (a + ~b + 1), 0 otherwise.
  function automatic logic carry_seed(input logic [2:0] op, input logic c_in);
    logic seed;
    case (op)
      OP_ADD:  seed = c_in;
      OP_SUB:  seed = 1'b1;
      default: seed = 1'b0;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/serial_alu_n_if.sv
// Request/result bundle of the serial ALU; master drives requests, slave answers.
interface serial_alu_n_if #(parameter int N = 8);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         c_out;
  logic         zero;

  modport master (output start, op, a, b, c_in,
                  input  busy, done, result, c_out, zero);
  modport slave  (input  start, op, a, b, c_in,
                  output busy, done, result, c_out, zero);
endinterface

// File: rtl/alu_chunk_w.sv
// One W-bit slice of the ALU; subtraction inverts b here so the caller only seeds the carry.
module alu_chunk_w
  import alu_n_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0] a_w,
  input  logic [W-1:0] b_w,
  input  logic         cin,
  input  logic [2:0]   op,
  output logic [W-1:0] y_w,
  output logic         cout
);

  logic [W-1:0] b_eff_s;
  logic [W:0]   sum_s;

  // Slice result and carry for the selected op; reserved codes yield zero.
  always_comb begin
    if (op == OP_SUB) begin
      b_eff_s = ~b_w;
    end else begin
      b_eff_s = b_w;
    end
    sum_s = {1'b0, a_w} + {1'b0, b_eff_s} + {{W{1'b0}}, cin};
    y_w   = {W{1'b0}};
    cout  = 1'b0;
    case (op)
      OP_AND: y_w = a_w & b_w;
      OP_OR:  y_w = a_w | b_w;
      OP_XOR: y_w = a_w ^ b_w;
      OP_ADD, OP_SUB: begin
        y_w  = sum_s[W-1:0];
        cout = sum_s[W];
      end
      default: begin
        y_w  = {W{1'b0}};
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_n.sv
// Multi-cycle N-bit ALU: W bits per cycle, LSB chunk first, carry held in a register
// between chunks; the visible result only changes when a whole operation completes.
module serial_alu_n
  import alu_n_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  serial_alu_n_if.slave  bus
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  if (W < 1 || W > N || (N % W) != 0) begin : g_param_check
    $error("serial_alu_n: W must satisfy 1 <= W <= N and divide N");
  end

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  a_r, b_r, work_r, work_s, result_r;
  logic [2:0]    op_r;
  logic          carry_r, busy_r, done_r, c_out_r, zero_r;
  logic          accept_s, last_s;
  logic [W-1:0]  a_chunk_s, b_chunk_s, y_chunk_s;
  logic          cout_chunk_s;

  assign a_chunk_s = a_r[cnt_r*W +: W];
  assign b_chunk_s = b_r[cnt_r*W +: W];

  alu_chunk_w #(.W(W)) u_chunk (
    .a_w  (a_chunk_s),
    .b_w  (b_chunk_s),
    .cin  (carry_r),
    .op   (op_r),
    .y_w  (y_chunk_s),
    .cout (cout_chunk_s)
  );

  // Working register with the current chunk merged in at its bit position.
  always_comb begin
    work_s = work_r;
    work_s[cnt_r*W +: W] = y_chunk_s;
  end

  // Next-state decode; accept and last-chunk strobes steer the register updates.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s  = S_RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_DONE;
          last_s  = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state, operand capture, chunk accumulation and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CW{1'b0}};
      a_r      <= {N{1'b0}};
      b_r      <= {N{1'b0}};
      op_r     <= 3'b000;
      carry_r  <= 1'b0;
      work_r   <= {N{1'b0}};
      result_r <= {N{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      c_out_r  <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= last_s;
      if (accept_s) begin
        a_r     <= bus.a;
        b_r     <= bus.b;
        op_r    <= bus.op;
        carry_r <= carry_seed(bus.op, bus.c_in);
        cnt_r   <= {CW{1'b0}};
        work_r  <= {N{1'b0}};
      end else if (state_r == S_RUN) begin
        work_r  <= work_s;
        carry_r <= cout_chunk_s;
        cnt_r   <= cnt_r + CW'(1);
      end
      if (last_s) begin
        result_r <= work_s;
        c_out_r  <= cout_chunk_s;
        zero_r   <= (work_s == {N{1'b0}});
      end
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.c_out  = c_out_r;
  assign bus.zero   = zero_r;

endmodule
